// File: rtl/code_lock_pkg.sv
// Shared types and default constants for the code lock controller.
package code_lock_pkg;
    typedef enum logic [1:0] {ST_LOCKED, ST_OPEN, ST_PROG, ST_LOCKOUT} state_e;

    localparam int          DEF_DIGIT_W     = 4;
    localparam int          DEF_CODE_LEN    = 4;
    localparam int          DEF_MAX_TRIES   = 3;
    localparam int          DEF_LOCKOUT_CYC = 16;
    localparam logic [15:0] DEF_RESET_CODE  = 16'h1234;
endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad-side bus of the code lock: digit entry, requests and status outputs.
interface code_lock_ctrl_if
    import code_lock_pkg::*;
#(
    parameter int DIGIT_W   = DEF_DIGIT_W,
    parameter int CODE_LEN  = DEF_CODE_LEN,
    parameter int MAX_TRIES = DEF_MAX_TRIES
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = $clog2(CODE_LEN + 1);

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_vld;
    logic               clear_in;
    logic               lock_req;
    logic               prog_req;
    logic               unlocked;
    logic               alarm;
    logic               fail_pulse;
    logic               code_updated;
    logic [TW-1:0]      tries_left;
    logic [CW-1:0]      digits_entered;

    modport master (
        output digit_in, digit_vld, clear_in, lock_req, prog_req,
        input  unlocked, alarm, fail_pulse, code_updated, tries_left, digits_entered
    );

    modport slave (
        input  digit_in, digit_vld, clear_in, lock_req, prog_req,
        output unlocked, alarm, fail_pulse, code_updated, tries_left, digits_entered
    );
endinterface

// File: rtl/code_lock_ctrl_lockout_timer.sv
// Down-counter timing the lockout period; done marks the last lockout cycle.
module lockout_timer #(
    parameter int LOCKOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int W = $clog2(LOCKOUT_CYC + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(LOCKOUT_CYC);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/code_lock_ctrl.sv
// Digit-entry code lock: LOCKED/OPEN/PROG/LOCKOUT FSM with registered outputs.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                           DIGIT_W     = DEF_DIGIT_W,
    parameter int                           CODE_LEN    = DEF_CODE_LEN,
    parameter int                           MAX_TRIES   = DEF_MAX_TRIES,
    parameter int                           LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE  = DEF_RESET_CODE
) (
    input logic             clk,
    input logic             rst,
    code_lock_ctrl_if.slave bus
);
    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int TW     = $clog2(MAX_TRIES + 1);
    localparam int CW     = $clog2(CODE_LEN + 1);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] entry_q, entry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tries_q, tries_d;
    logic              unlocked_q, unlocked_d;
    logic              alarm_q, alarm_d;
    logic              fail_q, fail_d;
    logic              upd_q, upd_d;
    logic              tmr_load, tmr_dec, tmr_done;
    logic [CODE_W-1:0] entry_shift;
    logic              last_digit;

    lockout_timer #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .done_o (tmr_done)
    );

    // New digit enters on the LSB side; the oldest digit falls off the top.
    assign entry_shift = CODE_W'({entry_q, bus.digit_in});
    assign last_digit  = (cnt_q == CW'(CODE_LEN - 1));

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        fail_d   = 1'b0;
        upd_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        unique case (state_q)
            ST_LOCKED: begin
                if (bus.clear_in) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (bus.digit_vld) begin
                    if (last_digit) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        if (entry_shift == code_q) begin
                            state_d = ST_OPEN;
                            tries_d = TW'(MAX_TRIES);
                        end else begin
                            fail_d  = 1'b1;
                            tries_d = tries_q - TW'(1);
                            if (tries_q == TW'(1)) begin
                                state_d  = ST_LOCKOUT;
                                tmr_load = 1'b1;
                            end
                        end
                    end else begin
                        entry_d = entry_shift;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            ST_OPEN: begin
                if (bus.lock_req) begin
                    state_d = ST_LOCKED;
                end else if (bus.prog_req) begin
                    state_d = ST_PROG;
                end
            end
            ST_PROG: begin
                if (bus.lock_req || bus.clear_in) begin
                    state_d = bus.lock_req ? ST_LOCKED : ST_OPEN;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (bus.digit_vld) begin
                    if (last_digit) begin
                        code_d  = entry_shift;
                        upd_d   = 1'b1;
                        state_d = ST_OPEN;
                        entry_d = '0;
                        cnt_d   = '0;
                    end else begin
                        entry_d = entry_shift;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (tmr_done) begin
                    state_d = ST_LOCKED;
                    tries_d = TW'(MAX_TRIES);
                end
            end
            default: state_d = ST_LOCKED;
        endcase

        unlocked_d = (state_d == ST_OPEN);
        alarm_d    = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOCKED;
            code_q     <= RESET_CODE;
            entry_q    <= '0;
            cnt_q      <= '0;
            tries_q    <= TW'(MAX_TRIES);
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            fail_q     <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
            fail_q     <= fail_d;
            upd_q      <= upd_d;
        end
    end

    assign bus.unlocked       = unlocked_q;
    assign bus.alarm          = alarm_q;
    assign bus.fail_pulse     = fail_q;
    assign bus.code_updated   = upd_q;
    assign bus.tries_left     = tries_q;
    assign bus.digits_entered = cnt_q;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: unlock, lockout, clear, reprogram, abort and reset cases.
module tb_code_lock_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    code_lock_ctrl_if bus_if ();

    code_lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.digit_in  = '0;
        bus_if.digit_vld = 1'b0;
        bus_if.clear_in  = 1'b0;
        bus_if.lock_req  = 1'b0;
        bus_if.prog_req  = 1'b0;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        bus_if.digit_in  = d;
        bus_if.digit_vld = 1'b1;
        step();
        bus_if.digit_vld = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) enter_digit(code[15-4*i -: 4]);
    endtask

    task automatic pulse_lock();
        bus_if.lock_req = 1'b1;
        step();
        bus_if.lock_req = 1'b0;
    endtask

    task automatic pulse_prog();
        bus_if.prog_req = 1'b1;
        step();
        bus_if.prog_req = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL reset_unlocked got %0b want 0", bus_if.unlocked); end
        n_cmp++; if (bus_if.alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm got %0b want 0", bus_if.alarm); end
        n_cmp++; if (bus_if.tries_left !== 2'd3) begin n_err++; $display("FAIL reset_tries got %0d want 3", bus_if.tries_left); end
        n_cmp++; if (bus_if.digits_entered !== 3'd0) begin n_err++; $display("FAIL reset_digits got %0d want 0", bus_if.digits_entered); end
        n_cmp++; if ({bus_if.fail_pulse, bus_if.code_updated} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {bus_if.fail_pulse, bus_if.code_updated}); end
    endtask

    task automatic test_unlock();
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd3);
        n_cmp++; if (bus_if.digits_entered !== 3'd3) begin n_err++; $display("FAIL partial_digits got %0d want 3", bus_if.digits_entered); end
        n_cmp++; if (bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL partial_unlocked got %0b want 0", bus_if.unlocked); end
        enter_digit(4'd4);
        n_cmp++; if (bus_if.unlocked !== 1'b1) begin n_err++; $display("FAIL unlock got %0b want 1", bus_if.unlocked); end
        n_cmp++; if (bus_if.tries_left !== 2'd3) begin n_err++; $display("FAIL unlock_tries got %0d want 3", bus_if.tries_left); end
        n_cmp++; if (bus_if.digits_entered !== 3'd0) begin n_err++; $display("FAIL unlock_digits got %0d want 0", bus_if.digits_entered); end
        n_cmp++; if (bus_if.fail_pulse !== 1'b0) begin n_err++; $display("FAIL unlock_fail got %0b want 0", bus_if.fail_pulse); end
        enter_digit(4'd7);
        n_cmp++; if (bus_if.digits_entered !== 3'd0) begin n_err++; $display("FAIL open_digit_ignored got %0d want 0", bus_if.digits_entered); end
        bus_if.lock_req = 1'b1;
        bus_if.prog_req = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL relock got %0b want 0", bus_if.unlocked); end
        step();
        n_cmp++; if (bus_if.code_updated !== 1'b0 || bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL lock_over_prog got upd=%0b unl=%0b want 0 0", bus_if.code_updated, bus_if.unlocked); end
    endtask

    task automatic fail_three_times();
        for (int t = 0; t < 3; t++) begin
            enter_code(16'h1235);
            n_cmp++; if (bus_if.fail_pulse !== 1'b1) begin n_err++; $display("FAIL fail_pulse_%0d got %0b want 1", t, bus_if.fail_pulse); end
            n_cmp++; if (bus_if.tries_left !== 2'(2 - t)) begin n_err++; $display("FAIL tries_%0d got %0d want %0d", t, bus_if.tries_left, 2 - t); end
            n_cmp++; if (bus_if.alarm !== (t == 2)) begin n_err++; $display("FAIL alarm_after_%0d got %0b want %0b", t, bus_if.alarm, t == 2); end
        end
    endtask

    task automatic test_lockout();
        int  alarm_cyc;
        bit  fail_seen;
        bit  digit_seen;
        fail_three_times();
        alarm_cyc  = 1;
        fail_seen  = 1'b0;
        digit_seen = 1'b0;
        bus_if.digit_in  = 4'd1;
        bus_if.digit_vld = 1'b1;
        bus_if.lock_req  = 1'b1;
        bus_if.prog_req  = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            if (!bus_if.alarm) break;
            alarm_cyc++;
            if (bus_if.fail_pulse) fail_seen = 1'b1;
            if (bus_if.digits_entered != 0 || bus_if.unlocked) digit_seen = 1'b1;
        end
        idle_inputs();
        n_cmp++; if (alarm_cyc !== 16) begin n_err++; $display("FAIL alarm_len got %0d want 16", alarm_cyc); end
        n_cmp++; if (fail_seen !== 1'b0) begin n_err++; $display("FAIL fail_pulse_width got extra pulse want single"); end
        n_cmp++; if (digit_seen !== 1'b0) begin n_err++; $display("FAIL lockout_inputs got accepted want ignored"); end
        n_cmp++; if (bus_if.tries_left !== 2'd3) begin n_err++; $display("FAIL lockout_exit_tries got %0d want 3", bus_if.tries_left); end
        n_cmp++; if (bus_if.alarm !== 1'b0 || bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL lockout_exit_state got alarm=%0b unl=%0b want 0 0", bus_if.alarm, bus_if.unlocked); end
    endtask

    task automatic test_clear();
        bit fail_seen;
        fail_seen = 1'b0;
        enter_digit(4'd1);
        enter_digit(4'd2);
        bus_if.clear_in = 1'b1;
        enter_digit(4'd9);
        bus_if.clear_in = 1'b0;
        n_cmp++; if (bus_if.digits_entered !== 3'd0) begin n_err++; $display("FAIL clear_digits got %0d want 0", bus_if.digits_entered); end
        for (int i = 1; i <= 4; i++) begin
            enter_digit(4'(i));
            if (bus_if.fail_pulse) fail_seen = 1'b1;
        end
        n_cmp++; if (fail_seen !== 1'b0) begin n_err++; $display("FAIL clear_no_fail got a fail pulse want none"); end
        n_cmp++; if (bus_if.unlocked !== 1'b1) begin n_err++; $display("FAIL clear_unlock got %0b want 1", bus_if.unlocked); end
        n_cmp++; if (bus_if.tries_left !== 2'd3) begin n_err++; $display("FAIL clear_tries got %0d want 3", bus_if.tries_left); end
        pulse_lock();
    endtask

    task automatic test_prog();
        enter_code(16'h1234);
        pulse_prog();
        n_cmp++; if (bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL prog_unlocked got %0b want 0", bus_if.unlocked); end
        enter_code(16'h9876);
        n_cmp++; if (bus_if.code_updated !== 1'b1) begin n_err++; $display("FAIL code_updated got %0b want 1", bus_if.code_updated); end
        n_cmp++; if (bus_if.unlocked !== 1'b1) begin n_err++; $display("FAIL prog_back_open got %0b want 1", bus_if.unlocked); end
        step();
        n_cmp++; if (bus_if.code_updated !== 1'b0) begin n_err++; $display("FAIL code_updated_width got %0b want 0", bus_if.code_updated); end
        pulse_lock();
        enter_code(16'h1234);
        n_cmp++; if (bus_if.fail_pulse !== 1'b1 || bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL old_code got fail=%0b unl=%0b want 1 0", bus_if.fail_pulse, bus_if.unlocked); end
        n_cmp++; if (bus_if.tries_left !== 2'd2) begin n_err++; $display("FAIL old_code_tries got %0d want 2", bus_if.tries_left); end
        enter_code(16'h9876);
        n_cmp++; if (bus_if.unlocked !== 1'b1 || bus_if.tries_left !== 2'd3) begin n_err++; $display("FAIL new_code got unl=%0b tries=%0d want 1 3", bus_if.unlocked, bus_if.tries_left); end
        pulse_prog();
        enter_code(16'h1234);
        pulse_lock();
    endtask

    task automatic test_prog_abort();
        enter_code(16'h1234);
        pulse_prog();
        enter_digit(4'd9);
        enter_digit(4'd8);
        n_cmp++; if (bus_if.digits_entered !== 3'd2) begin n_err++; $display("FAIL prog_partial got %0d want 2", bus_if.digits_entered); end
        bus_if.clear_in  = 1'b1;
        bus_if.digit_in  = 4'd7;
        bus_if.digit_vld = 1'b1;
        pulse_lock();
        idle_inputs();
        n_cmp++; if (bus_if.unlocked !== 1'b0 || bus_if.digits_entered !== 3'd0 || bus_if.code_updated !== 1'b0) begin
            n_err++; $display("FAIL prog_abort got unl=%0b dig=%0d upd=%0b want 0 0 0", bus_if.unlocked, bus_if.digits_entered, bus_if.code_updated);
        end
        enter_code(16'h1234);
        n_cmp++; if (bus_if.unlocked !== 1'b1) begin n_err++; $display("FAIL prog_abort_code got %0b want 1", bus_if.unlocked); end
        pulse_lock();
    endtask

    task automatic test_reset_lockout();
        fail_three_times();
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus_if.alarm !== 1'b1) begin n_err++; $display("FAIL lockout_cycle5 got %0b want 1", bus_if.alarm); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bus_if.alarm !== 1'b0 || bus_if.unlocked !== 1'b0) begin n_err++; $display("FAIL rst_lockout got alarm=%0b unl=%0b want 0 0", bus_if.alarm, bus_if.unlocked); end
        n_cmp++; if (bus_if.tries_left !== 2'd3) begin n_err++; $display("FAIL rst_lockout_tries got %0d want 3", bus_if.tries_left); end
        enter_code(16'h1234);
        n_cmp++; if (bus_if.unlocked !== 1'b1) begin n_err++; $display("FAIL rst_lockout_unlock got %0b want 1", bus_if.unlocked); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_unlock();
        test_lockout();
        test_clear();
        test_prog();
        test_prog_abort();
        test_reset_lockout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameter DIGIT_W, default 4, width of one entered digit.
REQ-002 Parameter CODE_LEN, default 4, digits per code, >=1.
REQ-003 Parameter MAX_TRIES, default 3, consecutive failed entries before lockout, >=1.
REQ-004 Parameter LOCKOUT_CYC, default 16, lockout duration in clk cycles, >=1.
REQ-005 Parameter RESET_CODE, default 16'h1234, CODE_LEN*DIGIT_W bits; first digit is the most significant.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 digit_in  in  DIGIT_W  entered digit.
REQ-009 digit_vld  in  1  digit_in accepted at this edge.
REQ-010 clear_in  in  1  discard the partial entry.
REQ-011 lock_req  in  1  relock request.
REQ-012 prog_req  in  1  start code reprogramming (OPEN only).
REQ-013 unlocked  out  1  high while in OPEN.
REQ-014 alarm  out  1  high while in LOCKOUT.
REQ-015 fail_pulse  out  1  one-cycle pulse per failed entry.
REQ-016 code_updated  out  1  one-cycle pulse when a new code is stored.
REQ-017 tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.
REQ-018 digits_entered  out  $clog2(CODE_LEN+1)  digits in the current partial entry.

Function
REQ-019 FSM states SHALL be LOCKED, OPEN, PROG and LOCKOUT; all outputs SHALL be registered.
REQ-020 In LOCKED or PROG, digit_vld SHALL shift digit_in into the entry register (LSB side) and increment digits_entered.
REQ-021 On acceptance of the CODE_LEN-th digit in LOCKED, the full entry including that digit SHALL be compared with the stored code at the same edge; digits_entered SHALL return to 0.
REQ-022 On match, next cycle: state OPEN, unlocked=1, tries_left=MAX_TRIES (1-cycle latency).
REQ-023 On mismatch, next cycle: fail_pulse=1 for one cycle and tries_left decremented; on reaching 0, state LOCKOUT, else LOCKED.
REQ-024 LOCKOUT: alarm=1 for exactly LOCKOUT_CYC cycles; then LOCKED, alarm=0, tries_left=MAX_TRIES; digit_vld, clear_in, lock_req and prog_req SHALL be ignored.
REQ-025 clear_in SHALL zero digits_entered without counting a failure; clear_in wins over a simultaneous digit_vld.
REQ-026 OPEN: lock_req -> LOCKED next cycle; otherwise prog_req -> PROG; digit_vld ignored; lock_req wins over simultaneous prog_req.
REQ-027 PROG: after the CODE_LEN-th digit the stored code SHALL update, code_updated pulses one cycle, state returns to OPEN.
REQ-028 PROG: clear_in -> OPEN, code unchanged; lock_req -> LOCKED, code unchanged; lock_req wins over clear_in and digit_vld.
REQ-029 A partial entry SHALL persist indefinitely; there is no inter-digit timeout.

Reset
REQ-030 rst SHALL force: state LOCKED, stored code=RESET_CODE, entry register 0, digits_entered=0, tries_left=MAX_TRIES, unlocked=alarm=fail_pulse=code_updated=0, lockout timer 0.
REQ-031 rst SHALL take priority over every other input, including mid-LOCKOUT and mid-PROG.

Structure
REQ-032 Package code_lock_pkg SHALL hold the state enum and default parameter constants.
REQ-033 The lockout counter SHALL be a sub-module lockout_timer: load, count-down and done outputs, width $clog2(LOCKOUT_CYC+1).
REQ-034 Target size is 120-400 lines of RTL, no latches, no combinational output paths.

Verification
REQ-035 Reset, enter 1,2,3,4 -> unlocked=1 the cycle after digit 4, tries_left=3.
REQ-036 Enter 1,2,3,5 three times -> three fail_pulses, tries_left 2,1,0; alarm=1 for exactly 16 cycles; digits ignored; then tries_left=3.
REQ-037 Enter 1,2, clear_in with digit_vld=1 (digit 9), then 1,2,3,4 -> no fail_pulse, unlock.
REQ-038 In OPEN, prog_req, enter 9,8,7,6 -> code_updated pulse; lock_req; 1,2,3,4 fails; 9,8,7,6 unlocks.
REQ-039 In PROG after 9,8, assert lock_req -> LOCKED next cycle, code remains 1234.
REQ-040 Assert rst in the 5th lockout cycle -> alarm=0, LOCKED, tries_left=3 next cycle; 1,2,3,4 unlocks.
